mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store unit between the execute stage and the data RAM.
//  Accepts one byte/half/word/double request per handshake, aligns lanes, builds a per-bit
//  write mask, and sign/zero-extends load data.
//  Waits any number of cycles for RAM read-valid or write-ack, then returns a one-cycle
//  response pulse.
//  Successor to the fixed 32-bit, zero-latency memory stage.
// PARAMETERS
//  DATA_W      64   RAM data width in bits; legal values 32 or 64
//  ADDR_W      64   byte-address width
//  TIMEOUT_CYC 256  RAM wait limit in cycles (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-low
//  req_valid    in   1       request valid
//  req_ready    out  1       unit idle, request accepted when valid&&ready
//  req_we       in   1       1=store, 0=load
//  req_size     in   2       0=byte 1=half 2=word 3=double
//  req_signed   in   1       load sign-extend (1) or zero-extend (0)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   DATA_W  store data, right-justified
//  resp_valid   out  1       one-cycle response pulse
//  resp_rdata   out  DATA_W  extended load data; 0 for stores and errors
//  resp_err     out  1       misaligned, illegal size, or timeout; qualified by resp_valid
//  ram_r_ena    out  1       RAM read request
//  ram_r_addr   out  ADDR_W  RAM read address, aligned to DATA_W word
//  ram_r_data   in   DATA_W  RAM read data
//  ram_r_valid  in   1       ram_r_data valid
//  ram_w_ena    out  1       RAM write request
//  ram_w_addr   out  ADDR_W  RAM write address, aligned to DATA_W word
//  ram_w_data   out  DATA_W  lane-shifted write data
//  ram_w_mask   out  DATA_W  per-bit write enable
//  ram_w_ack    in   1       RAM write accepted
// BEHAVIOUR
//  - Reset (rst==0 at posedge) forces state IDLE.
//    Reset values: req_ready=1; every other output 0; timeout counter 0.
//  - FSM states: IDLE, RD, WR, RESP. All outputs are registered.
//  - IDLE: req_ready=1. On accept, latch the request.
//    Illegal request (addr % (1<<size) != 0, or size==3 with DATA_W==32) -> RESP with err=1;
//      no RAM access.
//    Legal load -> RD. Legal store -> WR.
//  - LANE = addr[log2(DATA_W/8)-1:0]. RAM address = addr with the LANE bits cleared.
//  - RD: ram_r_ena=1 and ram_r_addr held.
//    On ram_r_valid: extract (8<<size) bits at bit offset LANE*8 and extend per req_signed.
//    Capture the result into resp_rdata, drop ram_r_ena, go to RESP.
//  - WR: ram_w_ena=1; ram_w_data = wdata[(8<<size)-1:0] << (LANE*8).
//    ram_w_mask has ones on exactly those bits, zeros elsewhere.
//    On ram_w_ack: drop ram_w_ena, resp_rdata=0, go to RESP.
//  - RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err are held until
//    the next response. No response backpressure.
//  - req_ready=0 in RD, WR and RESP; one request in flight.
//  - Minimum latency: accept at T, RAM enable at T+1; handshake at T+1 gives resp_valid at T+2.
//    Illegal requests give resp_valid at T+1.
//  - ram_r_valid/ram_w_ack arriving outside RD/WR are ignored.
//  - Reset mid-operation abandons the request with no response. A late RAM handshake after
//    reset is ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - A counter clears on entry to RD/WR and increments each waiting cycle.
//   - If it reaches TIMEOUT_CYC-1 with no handshake: drop the RAM enable, go to RESP with
//     resp_err=1 and resp_rdata=0.
//   - A handshake in the same cycle wins over the timeout.
//  MEM_TIMEOUT_EN undefined: no counter; RD/WR wait indefinitely. resp_err reports illegal
//  requests only.
// TESTING
//  1. DATA_W=64: load size=0 signed, addr=0x1003, RAM word 0x0000_0000_8000_0000.
//     -> ram_r_addr=0x1000; resp_rdata=0xFFFF_FFFF_FFFF_FF80; err=0.
//  2. Store size=1, addr=0x2006, wdata=0xBEEF, ack 3 cycles late.
//     -> ram_w_data=0xBEEF_0000_0000_0000, mask=0xFFFF_0000_0000_0000.
//     -> ram_w_ena held 3 cycles; a single resp_valid pulse.
//  3. Load size=2, addr=0x3002 (misaligned).
//     -> no ram_r_ena; resp_valid at T+1 with resp_err=1, rdata=0.
//  4. Load size=2 unsigned at 0x4004, RAM 0xF000_0001_0000_0000, valid same cycle.
//     -> resp_rdata=0x0000_0000_F000_0001 at T+2.
//     -> back-to-back request accepted the cycle after resp_valid.
//  5. Pull rst low while in RD, then assert ram_r_valid after reset.
//     -> outputs return to reset values; no resp_valid; req_ready=1.
//  6. MEM_TIMEOUT_EN, TIMEOUT_CYC=8, ram_r_valid never asserted.
//     -> ram_r_ena drops after 8 cycles; resp_valid with resp_err=1.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Signal bundle between the execute stage, mem_access_unit and the data RAM.
// The unit takes the slave modport; the requester and the RAM model drive the master side.
interface mem_access_unit_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    // Handshake rules: a request transfers on a posedge with req_valid && req_ready.
    // resp_valid is a one-cycle pulse with no backpressure. ram_r_valid / ram_w_ack
    // complete a RAM access only while the matching enable is high; otherwise ignored.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              ram_r_ena;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0] ram_r_data;
    logic              ram_r_valid;
    logic              ram_w_ena;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_w_mask;
    logic              ram_w_ack;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  ram_r_data, ram_r_valid, ram_w_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_r_ena, ram_r_addr, ram_w_ena, ram_w_addr, ram_w_data, ram_w_mask
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output ram_r_data, ram_r_valid, ram_w_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_r_ena, ram_r_addr, ram_w_ena, ram_w_addr, ram_w_data, ram_w_mask
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: lane alignment, per-bit write mask, load extension, variable RAM latency.
// Optional RAM wait timeout enabled by defining MEM_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module mem_access_unit #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam int LANE_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

    state_t            state, state_n;
    logic              req_ready_q, req_ready_n;
    logic              resp_valid_q, resp_valid_n;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_n;
    logic              resp_err_q, resp_err_n;
    logic              r_ena_q, r_ena_n;
    logic [ADDR_W-1:0] r_addr_q, r_addr_n;
    logic              w_ena_q, w_ena_n;
    logic [ADDR_W-1:0] w_addr_q, w_addr_n;
    logic [DATA_W-1:0] w_data_q, w_data_n;
    logic [DATA_W-1:0] w_mask_q, w_mask_n;
    logic [1:0]        lat_size, lat_size_n;
    logic              lat_signed, lat_signed_n;
    logic [LANE_W-1:0] lat_lane, lat_lane_n;

    logic [LANE_W-1:0] req_lane;
    logic [ADDR_W-1:0] req_word_addr;
    logic              misalign, illegal;
    int                wr_bits;
    logic [DATA_W-1:0] wr_field, wr_data, wr_mask;

    assign req_lane      = bus.req_addr[LANE_W-1:0];
    assign req_word_addr = {bus.req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

    always_comb begin
        wr_bits  = 8 << bus.req_size;
        wr_field = ~({DATA_W{1'b1}} << wr_bits);
        wr_mask  = wr_field << {req_lane, 3'b000};
        wr_data  = (bus.req_wdata & wr_field) << {req_lane, 3'b000};
        case (bus.req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = bus.req_addr[0];
            2'd2:    misalign = |bus.req_addr[1:0];
            default: misalign = |bus.req_addr[2:0];
        endcase
        illegal = misalign || (bus.req_size == 2'd3 && DATA_W == 32);
    end

    // Load extension: push the field to the top of the word, then shift back
    // arithmetically (signed) or logically (unsigned).
    int                       rd_shamt;
    logic [DATA_W-1:0]        rd_shift, rd_left, load_ext;
    logic signed [DATA_W-1:0] rd_sext;

    always_comb begin
        rd_shamt = DATA_W - (8 << lat_size);
        rd_shift = bus.ram_r_data >> {lat_lane, 3'b000};
        rd_left  = rd_shift << rd_shamt;
        rd_sext  = $signed(rd_left) >>> rd_shamt;
        load_ext = lat_signed ? rd_sext : (rd_left >> rd_shamt);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_n = (state == RD || state == WR) ? tmo_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) tmo_cnt <= '0;
        else      tmo_cnt <= tmo_cnt_n;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_n      = state;
        req_ready_n  = req_ready_q;
        resp_valid_n = resp_valid_q;
        resp_rdata_n = resp_rdata_q;
        resp_err_n   = resp_err_q;
        r_ena_n      = r_ena_q;
        r_addr_n     = r_addr_q;
        w_ena_n      = w_ena_q;
        w_addr_n     = w_addr_q;
        w_data_n     = w_data_q;
        w_mask_n     = w_mask_q;
        lat_size_n   = lat_size;
        lat_signed_n = lat_signed;
        lat_lane_n   = lat_lane;
        case (state)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_n  = 1'b0;
                    lat_size_n   = bus.req_size;
                    lat_signed_n = bus.req_signed;
                    lat_lane_n   = req_lane;
                    if (illegal) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end else if (bus.req_we) begin
                        state_n  = WR;
                        w_ena_n  = 1'b1;
                        w_addr_n = req_word_addr;
                        w_data_n = wr_data;
                        w_mask_n = wr_mask;
                    end else begin
                        state_n  = RD;
                        r_ena_n  = 1'b1;
                        r_addr_n = req_word_addr;
                    end
                end
            end
            RD: begin
                if (bus.ram_r_valid) begin
                    state_n      = RESP;
                    r_ena_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = load_ext;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n      = RESP;
                    r_ena_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                    resp_rdata_n = '0;
                end
`endif
            end
            WR: begin
                if (bus.ram_w_ack) begin
                    state_n      = RESP;
                    w_ena_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = '0;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n      = RESP;
                    w_ena_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                    resp_rdata_n = '0;
                end
`endif
            end
            default: begin
                state_n      = IDLE;
                resp_valid_n = 1'b0;
                req_ready_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            r_ena_q      <= 1'b0;
            r_addr_q     <= '0;
            w_ena_q      <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            w_mask_q     <= '0;
            lat_size     <= '0;
            lat_signed   <= 1'b0;
            lat_lane     <= '0;
        end else begin
            state        <= state_n;
            req_ready_q  <= req_ready_n;
            resp_valid_q <= resp_valid_n;
            resp_rdata_q <= resp_rdata_n;
            resp_err_q   <= resp_err_n;
            r_ena_q      <= r_ena_n;
            r_addr_q     <= r_addr_n;
            w_ena_q      <= w_ena_n;
            w_addr_q     <= w_addr_n;
            w_data_q     <= w_data_n;
            w_mask_q     <= w_mask_n;
            lat_size     <= lat_size_n;
            lat_signed   <= lat_signed_n;
            lat_lane     <= lat_lane_n;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.ram_r_ena  = r_ena_q;
    assign bus.ram_r_addr = r_addr_q;
    assign bus.ram_w_ena  = w_ena_q;
    assign bus.ram_w_addr = w_addr_q;
    assign bus.ram_w_data = w_data_q;
    assign bus.ram_w_mask = w_mask_q;
    assign dbg_state      = state;
endmodule
